dnlink_sequencer: RTL and testbench

Downlink telemetry sequencer for the inout section. It double-buffers the two downlink words written by software to channels 34 and 35, plus a word-order bit. On each start pulse from the downlink equipment it serialises order bit, word 1 and word 2, MSB first, one bit per bit-sync pulse. When the buffers are consumed it raises the downlink interrupt request so software can reload for the next frame.

---
 rtl/dnlink_pkg.sv | 22 ++
 rtl/dnlink_buffer.sv | 44 ++++
 rtl/dnlink_sequencer.sv | 106 ++++++++++
 tb/tb_dnlink_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dnlink_pkg.sv
// Shared types and constants for the downlink telemetry sequencer.
package dnlink_pkg;

  // Sequencer states: waiting for a frame start, or serialising a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of the bit-index counter; covers 0..2*WORD_W for WORD_W up to 31.
  localparam int CTR_W = 6;

  // Default word width and the matching frame length (order bit + two words).
  localparam int WORD_W_DEF = 16;

  function automatic int frame_bits(input int word_w);
    return 2 * word_w + 1;
  endfunction

  localparam int FRAME_BITS = frame_bits(WORD_W_DEF);

endpackage

// File: rtl/dnlink_buffer.sv
// Software-facing holding registers for downlink words 1 and 2 plus the
// word-order bit. Each word carries a "loaded" flag that the sequencer clears
// when it snapshots the buffers; a write in the same cycle keeps its flag set.
module dnlink_buffer
  import dnlink_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              WCH34,
  input  logic              WCH35,
  input  logic [WORD_W-1:0] CHWL,
  input  logic              ORDIN,
  input  logic              clr,
  output logic [WORD_W-1:0] h34,
  output logic [WORD_W-1:0] h35,
  output logic              hord,
  output logic              l34,
  output logic              l35
);

  // Holding registers and loaded flags; a write beats a same-cycle clear.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      h34  <= '0;
      h35  <= '0;
      hord <= 1'b0;
      l34  <= 1'b0;
      l35  <= 1'b0;
    end else begin
      if (WCH34) begin
        h34  <= CHWL;
        hord <= ORDIN;
      end
      if (WCH35) begin
        h35 <= CHWL;
      end
      l34 <= WCH34 | (l34 & ~clr);
      l35 <= WCH35 | (l35 & ~clr);
    end
  end

endmodule

// File: rtl/dnlink_sequencer.sv
// Downlink telemetry sequencer. On a frame start it snapshots the holding
// registers into a frame shift register and sends order bit, word 1, word 2,
// MSB first, one bit per bit-sync pulse. All outputs come straight from flops.
module dnlink_sequencer
  import dnlink_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              DKSTRT,
  input  logic              DKBSNC,
  input  logic              WCH34,
  input  logic              WCH35,
  input  logic [WORD_W-1:0] CHWL,
  input  logic              ORDIN,
  output logic              DKDATA,
  output logic [CTR_W-1:0]  DKCTR,
  output logic              BUSY,
  output logic              DLKRPT,
  output logic              STALE,
  output logic              ERRSTRT
);

  localparam int FB = frame_bits(WORD_W);
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(FB - 1);

  state_t              state;
  logic [FB-1:0]       sr;
  logic [WORD_W-1:0]   h34;
  logic [WORD_W-1:0]   h35;
  logic                hord;
  logic                l34;
  logic                l35;
  logic                take_start;

  // A start is only honoured from IDLE; this also clears the loaded flags.
  assign take_start = (state == IDLE) && DKSTRT;

  dnlink_buffer #(.WORD_W(WORD_W)) u_buffer (
    .CLOCK (CLOCK),
    .rst   (rst),
    .WCH34 (WCH34),
    .WCH35 (WCH35),
    .CHWL  (CHWL),
    .ORDIN (ORDIN),
    .clr   (take_start),
    .h34   (h34),
    .h35   (h35),
    .hord  (hord),
    .l34   (l34),
    .l35   (l35)
  );

  // The frame register MSB is the current bit; it is zeroed whenever idle,
  // so the serial line rests low without extra gating.
  assign DKDATA = sr[FB-1];

  // Frame FSM: snapshot on start, shift on bit-sync, flag starts while busy.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      DKCTR   <= '0;
      BUSY    <= 1'b0;
      DLKRPT  <= 1'b0;
      STALE   <= 1'b0;
      ERRSTRT <= 1'b0;
    end else begin
      DLKRPT  <= 1'b0;
      ERRSTRT <= 1'b0;
      case (state)
        IDLE: begin
          // Bit-sync is ignored here, even when it coincides with a start.
          if (DKSTRT) begin
            sr     <= {hord, h34, h35};
            DKCTR  <= '0;
            BUSY   <= 1'b1;
            STALE  <= ~(l34 & l35);
            DLKRPT <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (DKSTRT) begin
            ERRSTRT <= 1'b1;
          end
          if (DKBSNC) begin
            if (DKCTR == LAST_IDX) begin
              sr    <= '0;
              DKCTR <= '0;
              BUSY  <= 1'b0;
              STALE <= 1'b0;
              state <= IDLE;
            end else begin
              sr    <= {sr[FB-2:0], 1'b0};
              DKCTR <= DKCTR + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dnlink_sequencer.sv
// Directed bench for dnlink_sequencer: inputs change and outputs are sampled
// on the falling clock edge, so each sample shows the effect of the preceding
// rising edge.
module tb_dnlink_sequencer;

  localparam int W  = 16;
  localparam int FB = 2 * W + 1;

  logic         CLOCK = 1'b0;
  logic         rst;
  logic         DKSTRT;
  logic         DKBSNC;
  logic         WCH34;
  logic         WCH35;
  logic [W-1:0] CHWL;
  logic         ORDIN;
  logic         DKDATA;
  logic [5:0]   DKCTR;
  logic         BUSY;
  logic         DLKRPT;
  logic         STALE;
  logic         ERRSTRT;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  dnlink_sequencer #(.WORD_W(W)) dut (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .DKSTRT  (DKSTRT),
    .DKBSNC  (DKBSNC),
    .WCH34   (WCH34),
    .WCH35   (WCH35),
    .CHWL    (CHWL),
    .ORDIN   (ORDIN),
    .DKDATA  (DKDATA),
    .DKCTR   (DKCTR),
    .BUSY    (BUSY),
    .DLKRPT  (DLKRPT),
    .STALE   (STALE),
    .ERRSTRT (ERRSTRT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_data"}, DKDATA, 0);
    chk({tag, "_ctr"}, DKCTR, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_dlkrpt"}, DLKRPT, 0);
    chk({tag, "_stale"}, STALE, 0);
    chk({tag, "_errstrt"}, ERRSTRT, 0);
  endtask

  // Single-cycle channel write; entered and left on a falling edge.
  task automatic wr(input bit ch35, input logic [W-1:0] d, input logic o);
    CHWL = d; ORDIN = o; WCH34 = !ch35; WCH35 = ch35;
    @(negedge CLOCK);
    WCH34 = 1'b0; WCH35 = 1'b0;
  endtask

  // Frame start pulse (optionally with bit-sync); any write strobes already
  // raised by the caller fall with it.
  task automatic start(input logic stale_exp, input logic bsnc_too);
    DKSTRT = 1'b1; DKBSNC = bsnc_too;
    @(negedge CLOCK);
    DKSTRT = 1'b0; DKBSNC = 1'b0; WCH34 = 1'b0; WCH35 = 1'b0;
    chk("start_dlkrpt", DLKRPT, 1);
    chk("start_busy", BUSY, 1);
    chk("start_ctr", DKCTR, 0);
    chk("start_stale", STALE, stale_exp);
    chk("start_errstrt", ERRSTRT, 0);
    @(negedge CLOCK);
    chk("dlkrpt_one_cycle", DLKRPT, 0);
  endtask

  // Walk a frame with bit-syncs 10 cycles apart. err_at injects a start while
  // busy after that index; last_err overlaps a start with the final bit-sync;
  // rst_at aborts with a reset after that index.
  task automatic run_frame(input logic [FB-1:0] f, input logic stale_exp,
                           input int err_at, input bit last_err, input int rst_at);
    chk("bit0", DKDATA, f[FB-1]);
    for (int i = 1; i <= FB; i++) begin
      DKBSNC = 1'b1;
      if (i == FB && last_err) DKSTRT = 1'b1;
      @(negedge CLOCK);
      DKBSNC = 1'b0; DKSTRT = 1'b0;
      if (i < FB) begin
        chk("ctr", DKCTR, i);
        chk("bit", DKDATA, f[FB-1-i]);
        chk("stale_hold", STALE, stale_exp);
        chk("busy_hold", BUSY, 1);
        chk("dlkrpt_quiet", DLKRPT, 0);
      end else begin
        chk("end_busy", BUSY, 0);
        chk("end_ctr", DKCTR, 0);
        chk("end_data", DKDATA, 0);
        chk("end_stale", STALE, 0);
        chk("end_errstrt", ERRSTRT, last_err);
        @(negedge CLOCK);
        chk("no_queue_busy", BUSY, 0);
        chk("no_queue_dlkrpt", DLKRPT, 0);
        chk("no_queue_errstrt", ERRSTRT, 0);
      end
      if (i == err_at) begin
        DKSTRT = 1'b1;
        @(negedge CLOCK);
        DKSTRT = 1'b0;
        chk("errstrt_pulse", ERRSTRT, 1);
        chk("errstrt_ctr", DKCTR, i);
        chk("errstrt_bit", DKDATA, f[FB-1-i]);
        chk("errstrt_no_dlkrpt", DLKRPT, 0);
        @(negedge CLOCK);
        chk("errstrt_one_cycle", ERRSTRT, 0);
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge CLOCK);
        rst = 1'b0;
        chk_quiet("midrst");
        DKBSNC = 1'b1;
        @(negedge CLOCK);
        DKBSNC = 1'b0;
        chk_quiet("midrst_bsnc");
        return;
      end
      repeat (9) @(negedge CLOCK);
    end
  endtask

  initial begin
    rst = 1'b1; DKSTRT = 1'b0; DKBSNC = 1'b0; WCH34 = 1'b0; WCH35 = 1'b0;
    CHWL = '0; ORDIN = 1'b0;
    repeat (3) @(negedge CLOCK);
    rst = 1'b0;
    chk_quiet("reset");

    // Basic frame.
    wr(1'b0, 16'hA5C3, 1'b1);
    wr(1'b1, 16'h0F0F, 1'b0);
    repeat (3) @(negedge CLOCK);
    chk_quiet("pre_start");
    start(1'b0, 1'b0);
    run_frame({1'b1, 16'hA5C3, 16'h0F0F}, 1'b0, -1, 1'b0, -1);

    // Stale frame: same data again.
    start(1'b1, 1'b0);
    run_frame({1'b1, 16'hA5C3, 16'h0F0F}, 1'b1, -1, 1'b0, -1);

    // Write racing start: old word goes out, new one stays loaded.
    CHWL = 16'h1234; ORDIN = 1'b0; WCH34 = 1'b1;
    start(1'b1, 1'b0);
    run_frame({1'b1, 16'hA5C3, 16'h0F0F}, 1'b1, -1, 1'b0, -1);
    wr(1'b1, 16'h00FF, 1'b0);

    // Start while busy at index 7, and a start overlapping the last bit-sync.
    start(1'b0, 1'b0);
    run_frame({1'b0, 16'h1234, 16'h00FF}, 1'b0, 7, 1'b1, -1);

    // Mid-frame reset at index 20.
    wr(1'b0, 16'hBEEF, 1'b1);
    wr(1'b1, 16'h1357, 1'b0);
    start(1'b0, 1'b0);
    run_frame({1'b1, 16'hBEEF, 16'h1357}, 1'b0, -1, 1'b0, 20);

    // Reset cleared the buffers and loaded flags.
    start(1'b1, 1'b0);
    run_frame({FB{1'b0}}, 1'b1, -1, 1'b0, -1);

    // Start and bit-sync together: order bit held until the next bit-sync.
    wr(1'b0, 16'h8001, 1'b1);
    wr(1'b1, 16'h8000, 1'b0);
    start(1'b0, 1'b1);
    repeat (4) @(negedge CLOCK);
    chk("cosync_ctr", DKCTR, 0);
    chk("cosync_bit", DKDATA, 1);
    run_frame({1'b1, 16'h8001, 16'h8000}, 1'b0, -1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
